// File: rtl/game_pkg.sv
// Shared game-level types and screen constants for the
// player sprite pipeline.
package game_pkg;

   localparam int COORD_W = 10;
   localparam int VEL_W   = 8;

   localparam logic [COORD_W-1:0] H_ACTIVE = 10'd640;
   localparam logic [COORD_W-1:0] V_ACTIVE = 10'd480;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_AIR    = 2'd1,
      ST_FROZEN = 2'd2
   } motion_state_e;

endpackage

// File: rtl/jump_input_sync.sv
// Brings the raw jump button into pix_clk and emits a
// one-cycle pulse on each synchronized rising edge.
module jump_input_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_async,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = btn_async;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player physics and animation sequencer; state
// advances only on the first pixel of vertical blank.
module player_motion_ctrl
   import game_pkg::*;
#(
   parameter logic [9:0] GROUND_Y   = 10'd300,
   parameter logic [9:0] CEIL_Y     = 10'd0,
   parameter logic [7:0] JUMP_VEL   = 8'd12,
   parameter logic [7:0] GRAVITY    = 8'd1,
   parameter logic [7:0] MAX_FALL   = 8'd12,
   parameter logic [9:0] V_ACT      = V_ACTIVE,
   parameter int         NUM_FRAMES = 4,
   parameter int         ANIM_DIV   = 6,
   parameter logic [1:0] AIR_FRAME  = 2'd1
) (
   input  logic       pix_clk,
   input  logic       rst_n,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       jump_btn,
   input  logic       freeze,
   output logic [9:0] player_y,
   output logic [1:0] anim_frame,
   output logic       airborne,
   output logic       landed,
   output logic       frame_tick
);

   localparam int DIV_W =
      (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST =
      DIV_W'(ANIM_DIV - 1);
   localparam logic [1:0] FRAME_LAST =
      2'(NUM_FRAMES - 1);
   localparam logic signed [8:0] FALL_LIM =
      -$signed({1'b0, MAX_FALL});
   localparam logic signed [10:0] GROUND_S =
      $signed({1'b0, GROUND_Y});
   localparam logic signed [10:0] CEIL_S =
      $signed({1'b0, CEIL_Y});

   motion_state_e     state_q, state_d;
   logic [9:0]        y_q, y_d;
   logic signed [7:0] vy_q, vy_d;
   logic [1:0]        frame_q, frame_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              pend_q, pend_d;
   logic              air_q, air_d;
   logic              landed_q, landed_d;
   logic              ftick_q, ftick_d;

   logic               jump_rise;
   logic               tick;
   logic               pend_eff;
   logic signed [10:0] y_next;
   logic signed [8:0]  vy_dec;

   jump_input_sync u_sync (
      .clk       (pix_clk),
      .rst_n     (rst_n),
      .btn_async (jump_btn),
      .rise      (jump_rise)
   );

   assign tick     = (hcount == 10'd0) && (vcount == V_ACT);
   assign pend_eff = pend_q | jump_rise;
   assign y_next   = $signed({1'b0, y_q})
                   - $signed({{3{vy_q[7]}}, vy_q});
   assign vy_dec   = $signed({vy_q[7], vy_q})
                   - $signed({1'b0, GRAVITY});

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      vy_d     = vy_q;
      frame_d  = frame_q;
      div_d    = div_q;
      pend_d   = pend_eff;
      air_d    = air_q;
      landed_d = 1'b0;
      ftick_d  = 1'b0;
      if (tick) begin
         // requests never outlive the tick that sees them
         pend_d  = 1'b0;
         ftick_d = 1'b1;
         unique case (state_q)
            ST_GROUND: begin
               if (freeze) begin
                  state_d = ST_FROZEN;
                  vy_d    = 8'sd0;
               end else if (pend_eff) begin
                  state_d = ST_AIR;
                  vy_d    = $signed(JUMP_VEL);
                  frame_d = AIR_FRAME;
               end else if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  frame_d = (frame_q == FRAME_LAST)
                          ? 2'd0 : frame_q + 2'd1;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            ST_AIR: begin
               frame_d = AIR_FRAME;
               if (freeze) begin
                  state_d = ST_FROZEN;
                  vy_d    = 8'sd0;
               end else if (y_next >= GROUND_S) begin
                  state_d  = ST_GROUND;
                  y_d      = GROUND_Y;
                  vy_d     = 8'sd0;
                  landed_d = 1'b1;
                  frame_d  = 2'd0;
                  div_d    = '0;
               end else if (y_next < CEIL_S) begin
                  y_d  = CEIL_Y;
                  vy_d = 8'sd0;
               end else begin
                  y_d  = y_next[9:0];
                  vy_d = (vy_dec < FALL_LIM)
                       ? FALL_LIM[7:0] : vy_dec[7:0];
               end
            end
            ST_FROZEN: begin
               vy_d = 8'sd0;
               if (!freeze) begin
                  state_d = (y_q == GROUND_Y)
                          ? ST_GROUND : ST_AIR;
               end
            end
            default: begin
               state_d = ST_GROUND;
            end
         endcase
         air_d = (state_d == ST_AIR);
      end
   end

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_GROUND;
         y_q      <= GROUND_Y;
         vy_q     <= 8'sd0;
         frame_q  <= 2'd0;
         div_q    <= '0;
         pend_q   <= 1'b0;
         air_q    <= 1'b0;
         landed_q <= 1'b0;
         ftick_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         vy_q     <= vy_d;
         frame_q  <= frame_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         air_q    <= air_d;
         landed_q <= landed_d;
         ftick_q  <= ftick_d;
      end
   end

   assign player_y   = y_q;
   assign anim_frame = frame_q;
   assign airborne   = air_q;
   assign landed     = landed_q;
   assign frame_tick = ftick_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: reset, walk cycle,
// jump arc, press timing, ceiling clamp and freeze.
module tb_player_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] hcount = 10'd5;
   logic [9:0] vcount = 10'd10;
   logic       jump_btn = 1'b0;
   logic       freeze = 1'b0;

   logic [9:0] y0, y1;
   logic [1:0] af0, af1;
   logic       air0, air1, land0, land1, ft0, ft1;

   int checks = 0;
   int failures = 0;
   int ft_cnt = 0;
   int exp_y [0:25];
   int ceil_y [0:9];

   always #5 clk = ~clk;

   player_motion_ctrl u0 (
      .pix_clk    (clk),
      .rst_n      (rst_n),
      .hcount     (hcount),
      .vcount     (vcount),
      .jump_btn   (jump_btn),
      .freeze     (freeze),
      .player_y   (y0),
      .anim_frame (af0),
      .airborne   (air0),
      .landed     (land0),
      .frame_tick (ft0)
   );

   player_motion_ctrl #(.CEIL_Y(10'd250)) u1 (
      .pix_clk    (clk),
      .rst_n      (rst_n),
      .hcount     (hcount),
      .vcount     (vcount),
      .jump_btn   (jump_btn),
      .freeze     (freeze),
      .player_y   (y1),
      .anim_frame (af1),
      .airborne   (air1),
      .landed     (land1),
      .frame_tick (ft1)
   );

   always @(negedge clk) if (ft0) ft_cnt++;

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      jump_btn = 1'b0;
      freeze   = 1'b0;
      hcount   = 10'd5;
      vcount   = 10'd10;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // returns at the negedge just after the tick edge
   task automatic do_tick();
      @(negedge clk);
      hcount = 10'd0;
      vcount = 10'd480;
      @(negedge clk);
      hcount = 10'd5;
      vcount = 10'd10;
   endtask

   task automatic press();
      @(negedge clk);
      jump_btn = 1'b1;
      repeat (4) @(negedge clk);
      jump_btn = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      exp_y = '{300, 288, 277, 267, 258, 250, 243, 237,
                232, 228, 225, 223, 222, 222, 223, 225,
                228, 232, 237, 243, 250, 258, 267, 277,
                288, 300};
      ceil_y = '{300, 288, 277, 267, 258,
                 250, 250, 250, 251, 253};

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_y", y0, 16'd300);
      chk("rst_anim", af0, 16'd0);
      chk("rst_air", air0, 16'd0);
      chk("rst_land", land0, 16'd0);
      chk("rst_ft", ft0, 16'd0);
      rst_n = 1'b1;

      // walk cycle, 30 ticks
      do_reset();
      ft_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         do_tick();
         chk("walk_ft", ft0, 16'd1);
         chk("walk_anim", af0, 16'((k / 6) % 4));
         @(negedge clk);
         chk("walk_hold", af0, 16'((k / 6) % 4));
         chk("walk_ft_lo", ft0, 16'd0);
      end
      chk("walk_ft_cnt", 16'(ft_cnt), 16'd30);

      // jump arc with extra presses at T5 and before landing
      do_reset();
      press();
      do_tick();
      chk("t0_air", air0, 16'd1);
      chk("t0_y", y0, 16'd300);
      chk("t0_anim", af0, 16'd1);
      for (int k = 1; k <= 25; k++) begin
         do_tick();
         chk($sformatf("jump_y_t%0d", k), y0, 16'(exp_y[k]));
         if (k < 25) chk("jump_air", air0, 16'd1);
         if (k == 5 || k == 23) press();
      end
      chk("t25_land", land0, 16'd1);
      chk("t25_air", air0, 16'd0);
      chk("t25_anim", af0, 16'd0);
      @(negedge clk);
      chk("t25_land_lo", land0, 16'd0);
      do_tick();
      chk("t26_air", air0, 16'd0);
      chk("t26_y", y0, 16'd300);

      // async reset mid-jump
      do_reset();
      press();
      for (int k = 0; k <= 5; k++) do_tick();
      chk("mid_y", y0, 16'd250);
      chk("mid_air", air0, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_y", y0, 16'd300);
      chk("arst_anim", af0, 16'd0);
      chk("arst_air", air0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // edge synced on the tick edge itself
      do_reset();
      @(negedge clk);
      jump_btn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      hcount = 10'd0;
      vcount = 10'd480;
      @(negedge clk);
      hcount = 10'd5;
      vcount = 10'd10;
      chk("edge_air", air0, 16'd1);
      chk("edge_y", y0, 16'd300);
      jump_btn = 1'b0;
      do_tick();
      chk("edge_t1_y", y0, 16'd288);

      // ceiling clamp on the CEIL_Y=250 instance
      do_reset();
      press();
      for (int k = 0; k <= 9; k++) begin
         do_tick();
         chk($sformatf("ceil_y_t%0d", k), y1, 16'(ceil_y[k]));
      end
      chk("ceil_air", air1, 16'd1);

      // freeze mid-air, presses ignored, release descends
      do_reset();
      press();
      for (int k = 0; k <= 4; k++) do_tick();
      chk("frz_pre_y", y0, 16'd258);
      freeze = 1'b1;
      for (int k = 0; k < 10; k++) begin
         do_tick();
         chk("frz_y", y0, 16'd258);
         chk("frz_anim", af0, 16'd1);
         chk("frz_air", air0, 16'd0);
         press();
      end
      freeze = 1'b0;
      do_tick();
      chk("rel_air", air0, 16'd1);
      chk("rel_y", y0, 16'd258);
      do_tick();
      chk("rel_y1", y0, 16'd258);
      do_tick();
      chk("rel_y2", y0, 16'd259);
      do_tick();
      chk("rel_y3", y0, 16'd261);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
